// File: rtl/vga_fill_ctrl.sv
// Rectangle fill engine for a linear frame buffer.
// Accepts one fill command at a time, clips it to the frame, optionally waits
// for vertical blanking, then streams one write per pixel in row-major order.
module vga_fill_ctrl #(
  parameter int unsigned PIXEL_WIDTH  = 640,
  parameter int unsigned PIXEL_HEIGHT = 480,
  parameter int unsigned PIXEL_DEPTH  = 8,
  localparam int unsigned XW = $clog2(PIXEL_WIDTH),
  localparam int unsigned YW = $clog2(PIXEL_HEIGHT),
  localparam int unsigned AW = $clog2(PIXEL_WIDTH * PIXEL_HEIGHT)
) (
  input  logic                   pxclk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [XW-1:0]          cmd_x,
  input  logic [YW-1:0]          cmd_y,
  input  logic [XW:0]            cmd_w,
  input  logic [YW:0]            cmd_h,
  input  logic [PIXEL_DEPTH-1:0] cmd_color,
  input  logic                   cmd_sync,
  input  logic                   vblank,
  input  logic                   abort,
  output logic                   wr_valid,
  input  logic                   wr_ready,
  output logic [AW-1:0]          wr_addr,
  output logic [PIXEL_DEPTH-1:0] wr_data,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  localparam logic [XW:0]   WIDTH_X  = (XW+1)'(PIXEL_WIDTH);
  localparam logic [YW:0]   HEIGHT_Y = (YW+1)'(PIXEL_HEIGHT);
  localparam logic [AW-1:0] WIDTH_A  = AW'(PIXEL_WIDTH);
  localparam logic [XW:0]   ONE_X    = (XW+1)'(1);
  localparam logic [YW:0]   ONE_Y    = (YW+1)'(1);

  typedef enum logic [1:0] {StIdle, StWaitVb, StFill, StFin} state_e;

  state_e                 r_state, w_state_next;
  logic [AW-1:0]          r_row_base, w_row_base_next;
  logic [XW:0]            r_col, w_col_next;
  logic [XW:0]            r_ew, w_ew_next;
  logic [YW:0]            r_row, w_row_next;
  logic [YW:0]            r_eh, w_eh_next;
  logic [PIXEL_DEPTH-1:0] r_color, w_color_next;
  logic                   r_err, w_err_next;

  logic [XW:0]   w_x_ext, w_room_x, w_clip_w;
  logic [YW:0]   w_y_ext, w_room_y, w_clip_h;
  logic          w_x_bad, w_y_bad, w_cmd_bad;
  logic [AW-1:0] w_origin;
  logic          w_col_last, w_row_last;

  // Command decode: origin check, clipping and origin address, all in the accept cycle
  always_comb begin
    w_x_ext   = {1'b0, cmd_x};
    w_y_ext   = {1'b0, cmd_y};
    w_x_bad   = (w_x_ext >= WIDTH_X);
    w_y_bad   = (w_y_ext >= HEIGHT_Y);
    w_cmd_bad = w_x_bad | w_y_bad | (cmd_w == '0) | (cmd_h == '0);
    w_room_x  = WIDTH_X - w_x_ext;
    w_room_y  = HEIGHT_Y - w_y_ext;
    w_clip_w  = (cmd_w < w_room_x) ? cmd_w : w_room_x;
    w_clip_h  = (cmd_h < w_room_y) ? cmd_h : w_room_y;
    w_origin  = AW'(cmd_y) * WIDTH_A + AW'(cmd_x);
    w_col_last = (r_col == (r_ew - ONE_X));
    w_row_last = (r_row == (r_eh - ONE_Y));
  end

  // State and datapath registers
  always_ff @(posedge pxclk) begin
    if (rst) begin
      r_state    <= StIdle;
      r_row_base <= '0;
      r_col      <= '0;
      r_ew       <= '0;
      r_row      <= '0;
      r_eh       <= '0;
      r_color    <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_row_base <= w_row_base_next;
      r_col      <= w_col_next;
      r_ew       <= w_ew_next;
      r_row      <= w_row_next;
      r_eh       <= w_eh_next;
      r_color    <= w_color_next;
      r_err      <= w_err_next;
    end
  end

  // Next-state, datapath updates and status outputs
  always_comb begin
    w_state_next    = r_state;
    w_row_base_next = r_row_base;
    w_col_next      = r_col;
    w_ew_next       = r_ew;
    w_row_next      = r_row;
    w_eh_next       = r_eh;
    w_color_next    = r_color;
    w_err_next      = r_err;
    cmd_ready       = 1'b0;
    busy            = 1'b0;
    wr_valid        = 1'b0;
    done            = 1'b0;
    err             = 1'b0;
    wr_addr         = r_row_base + AW'(r_col);
    wr_data         = r_color;

    unique case (r_state)
      StIdle: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          if (w_cmd_bad) begin
            // Only an off-frame origin is an error; empty rectangles just complete
            w_err_next   = w_x_bad | w_y_bad;
            w_state_next = StFin;
          end else begin
            w_err_next      = 1'b0;
            w_ew_next       = w_clip_w;
            w_eh_next       = w_clip_h;
            w_color_next    = cmd_color;
            w_row_base_next = w_origin;
            w_col_next      = '0;
            w_row_next      = '0;
            w_state_next    = cmd_sync ? StWaitVb : StFill;
          end
        end
      end
      StWaitVb: begin
        busy = 1'b1;
        if (abort) begin
          w_state_next = StIdle;
        end else if (vblank) begin
          w_state_next = StFill;
        end
      end
      StFill: begin
        busy     = 1'b1;
        wr_valid = 1'b1;
        if (wr_ready) begin
          if (w_col_last) begin
            w_col_next = '0;
            if (w_row_last) begin
              w_state_next = StFin;
            end else begin
              // Advance only when another row follows so the base never passes the frame end
              w_row_base_next = r_row_base + WIDTH_A;
              w_row_next      = r_row + ONE_Y;
            end
          end else begin
            w_col_next = r_col + ONE_X;
          end
        end
        // Abort overrides completion; a same-cycle write still counts as issued
        if (abort) begin
          w_state_next = StIdle;
        end
      end
      StFin: begin
        busy         = 1'b1;
        done         = 1'b1;
        err          = r_err;
        w_state_next = StIdle;
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase

    // Reset forces all status and handshake outputs low immediately
    if (rst) begin
      cmd_ready = 1'b0;
      busy      = 1'b0;
      wr_valid  = 1'b0;
      done      = 1'b0;
      err       = 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_fill_ctrl.sv
// Self-checking bench for vga_fill_ctrl at the default 640x480x8 geometry.
module tb_vga_fill_ctrl;

  localparam int unsigned PW = 640;
  localparam int unsigned PH = 480;
  localparam int unsigned PD = 8;
  localparam int unsigned XW = 10;
  localparam int unsigned YW = 9;
  localparam int unsigned AW = 19;

  logic          pxclk = 1'b0;
  logic          rst;
  logic          cmd_valid, cmd_ready;
  logic [XW-1:0] cmd_x;
  logic [YW-1:0] cmd_y;
  logic [XW:0]   cmd_w;
  logic [YW:0]   cmd_h;
  logic [PD-1:0] cmd_color;
  logic          cmd_sync, vblank, abort;
  logic          wr_valid, wr_ready;
  logic [AW-1:0] wr_addr;
  logic [PD-1:0] wr_data;
  logic          busy, done, err;

  vga_fill_ctrl dut (
    .pxclk     (pxclk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_x     (cmd_x),
    .cmd_y     (cmd_y),
    .cmd_w     (cmd_w),
    .cmd_h     (cmd_h),
    .cmd_color (cmd_color),
    .cmd_sync  (cmd_sync),
    .vblank    (vblank),
    .abort     (abort),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 pxclk = ~pxclk;

  typedef struct {
    int unsigned addr;
    int unsigned data;
  } wr_t;

  typedef struct {
    int unsigned x, y, w, h, color;
    int unsigned exp_n;
    bit          exp_err;
  } vec_t;

  wr_t exp_q[$];
  wr_t mon_e;

  int checks = 0;
  int failures = 0;
  int n_wr = 0;
  int n_done = 0;
  bit bp_en = 1'b0;

  logic          prev_stall = 1'b0;
  logic [AW-1:0] prev_addr;
  logic [PD-1:0] prev_data;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge pxclk);
    #1;
  endtask

  // Reference model: every pixel of the clipped rectangle, row-major
  task automatic push_exp(input int unsigned x, y, w, h, color);
    int unsigned ew, eh;
    wr_t e;
    if (x >= PW || y >= PH || w == 0 || h == 0) return;
    ew = (w < PW - x) ? w : PW - x;
    eh = (h < PH - y) ? h : PH - y;
    for (int unsigned r = 0; r < eh; r++) begin
      for (int unsigned c = 0; c < ew; c++) begin
        e.addr = (y + r) * PW + x + c;
        e.data = color;
        exp_q.push_back(e);
      end
    end
  endtask

  // Returns just after the accept edge
  task automatic send_cmd(input int unsigned x, y, w, h, color, input bit sync);
    push_exp(x, y, w, h, color);
    cmd_x     = XW'(x);
    cmd_y     = YW'(y);
    cmd_w     = (XW+1)'(w);
    cmd_h     = (YW+1)'(h);
    cmd_color = PD'(color);
    cmd_sync  = sync;
    cmd_valid = 1'b1;
    for (int i = 0; i < 50 && !cmd_ready; i++) tick();
    if (!cmd_ready) chk("cmd_ready_wait", 0, 1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit got, output bit err_seen, output int cyc);
    got = 1'b0;
    err_seen = 1'b0;
    cyc = budget;
    for (int i = 0; i < budget; i++) begin
      if (done) begin
        got = 1'b1;
        err_seen = err;
        cyc = i;
        break;
      end
      tick();
    end
  endtask

  // Pseudo-random backpressure
  always @(posedge pxclk) begin
    if (bp_en) begin
      #1;
      wr_ready = 1'($urandom_range(0, 1));
    end
  end

  // Write monitor / scoreboard, sampled mid-cycle
  always @(negedge pxclk) begin
    if (!rst) begin
      if (prev_stall && wr_valid) begin
        chk("stall_addr", wr_addr, prev_addr);
        chk("stall_data", wr_data, prev_data);
      end
      if (wr_valid && wr_ready) begin
        n_wr++;
        chk("addr_in_frame", (wr_addr < PW * PH) ? 1 : 0, 1);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write: got addr %0d, required no write", wr_addr);
        end else begin
          mon_e = exp_q.pop_front();
          chk("wr_addr", wr_addr, mon_e.addr);
          chk("wr_data", wr_data, mon_e.data);
        end
      end
      if (done) n_done++;
    end
    prev_stall = !rst && wr_valid && !wr_ready;
    prev_addr  = wr_addr;
    prev_data  = wr_data;
  end

  initial begin
    vec_t vecs[9];
    bit got, err_seen;
    int cyc, w0, d0, bad;

    vecs[0] = '{x: 10,  y: 2,   w: 3,  h: 2,  color: 'hE0, exp_n: 6,  exp_err: 0};
    vecs[1] = '{x: 638, y: 479, w: 5,  h: 4,  color: 'h1C, exp_n: 2,  exp_err: 0};
    vecs[2] = '{x: 640, y: 0,   w: 3,  h: 3,  color: 'h55, exp_n: 0,  exp_err: 1};
    vecs[3] = '{x: 5,   y: 5,   w: 0,  h: 3,  color: 'h12, exp_n: 0,  exp_err: 0};
    vecs[4] = '{x: 0,   y: 480, w: 2,  h: 2,  color: 'h34, exp_n: 0,  exp_err: 1};
    vecs[5] = '{x: 0,   y: 0,   w: 1,  h: 1,  color: 'hFF, exp_n: 1,  exp_err: 0};
    vecs[6] = '{x: 630, y: 0,   w: 20, h: 1,  color: 'h03, exp_n: 10, exp_err: 0};
    vecs[7] = '{x: 0,   y: 470, w: 2,  h: 20, color: 'hA5, exp_n: 20, exp_err: 0};
    vecs[8] = '{x: 100, y: 100, w: 4,  h: 0,  color: 'h77, exp_n: 0,  exp_err: 0};

    rst = 1'b1; cmd_valid = 1'b0; cmd_x = '0; cmd_y = '0; cmd_w = '0; cmd_h = '0;
    cmd_color = '0; cmd_sync = 1'b0; vblank = 1'b0; abort = 1'b0; wr_ready = 1'b1;

    // Reset state
    repeat (3) tick();
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wr_valid", wr_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    rst = 1'b0;
    tick();
    chk("post_rst_cmd_ready", cmd_ready, 1);
    chk("post_rst_busy", busy, 0);

    // Table-driven commands with full-rate wr_ready
    foreach (vecs[k]) begin
      w0 = n_wr;
      send_cmd(vecs[k].x, vecs[k].y, vecs[k].w, vecs[k].h, vecs[k].color, 1'b0);
      chk($sformatf("v%0d_wr_valid_after_accept", k), wr_valid, (vecs[k].exp_n > 0) ? 1 : 0);
      wait_done(100, got, err_seen, cyc);
      chk($sformatf("v%0d_done_seen", k), got, 1);
      chk($sformatf("v%0d_err", k), err_seen, vecs[k].exp_err);
      chk($sformatf("v%0d_done_latency", k), cyc, vecs[k].exp_n);
      chk($sformatf("v%0d_write_count", k), n_wr - w0, vecs[k].exp_n);
      chk($sformatf("v%0d_queue_left", k), exp_q.size(), 0);
      tick();
      chk($sformatf("v%0d_cmd_ready_after", k), cmd_ready, 1);
      chk($sformatf("v%0d_done_pulse", k), done, 0);
    end

    // Backpressure: 4x4 with random wr_ready
    w0 = n_wr;
    bp_en = 1'b1;
    send_cmd(20, 30, 4, 4, 'h6B, 1'b0);
    wait_done(400, got, err_seen, cyc);
    bp_en = 1'b0;
    chk("bp_done_seen", got, 1);
    chk("bp_write_count", n_wr - w0, 16);
    chk("bp_queue_left", exp_q.size(), 0);
    tick();
    wr_ready = 1'b1;

    // Sync: hold in WAIT_VB until vblank
    send_cmd(0, 0, 2, 1, 'h81, 1'b1);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (wr_valid) bad++;
      tick();
    end
    chk("sync_no_wr_valid", bad, 0);
    chk("sync_busy", busy, 1);
    vblank = 1'b1;
    chk("sync_vb_cycle_wr_valid", wr_valid, 0);
    tick();
    vblank = 1'b0;
    chk("sync_wr_valid_after_vb", wr_valid, 1);
    wait_done(50, got, err_seen, cyc);
    chk("sync_done_latency", cyc, 2);
    tick();

    // Abort after 5th write, with a 6th handshake in the abort cycle
    w0 = n_wr; d0 = n_done;
    send_cmd(100, 10, 4, 4, 'h3C, 1'b0);
    repeat (5) tick();
    chk("abort_writes_before", n_wr - w0, 5);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_same_cycle_write", n_wr - w0, 6);
    chk("abort_wr_valid", wr_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_cmd_ready", cmd_ready, 1);
    repeat (4) tick();
    chk("abort_no_done", n_done - d0, 0);
    exp_q.delete();

    // Reset mid-fill
    w0 = n_wr; d0 = n_done;
    send_cmd(200, 50, 4, 4, 'hC3, 1'b0);
    repeat (5) tick();
    rst = 1'b1;
    tick();
    chk("midrst_wr_valid", wr_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_cmd_ready", cmd_ready, 0);
    chk("midrst_done", done, 0);
    chk("midrst_err", err, 0);
    chk("midrst_write_count", n_wr - w0, 5);
    rst = 1'b0;
    exp_q.delete();
    tick();
    chk("midrst_cmd_ready_after", cmd_ready, 1);
    repeat (3) tick();
    chk("midrst_no_done", n_done - d0, 0);

    // Abort is ignored in FIN and in IDLE
    send_cmd(5, 5, 0, 2, 'h00, 1'b0);
    abort = 1'b1;
    chk("fin_abort_done", done, 1);
    tick();
    chk("fin_abort_cmd_ready", cmd_ready, 1);
    w0 = n_wr;
    send_cmd(7, 7, 1, 1, 'h33, 1'b0);
    abort = 1'b0;
    wait_done(20, got, err_seen, cyc);
    chk("idle_abort_done", got, 1);
    chk("idle_abort_write", n_wr - w0, 1);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
